cfg_stream_loader: RTL

- Upstream feeder for the fabric configuration chain. Accepts a 32-bit word stream (valid/ready) carrying a header and column payload.
- Packs words into CFG_HEIGHT-bit columns and drives the fabric's shift/cdata chain, one column per shift pulse.
- Holds the fabric in reset until the load completes, so PCPI traffic only reaches a fully configured fabric.

---
 rtl/cfg_pkg.sv | 29 ++
 rtl/cfg_col_packer.sv | 54 +++++
 rtl/cfg_stream_loader.sv | 119 +++++++++++
 3 files changed

// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration stream loader: header tag,
// header field positions, FSM state encoding and the words-per-column helper.
// Pure declarations; no logic or timing of its own.
package cfg_pkg;

  localparam logic [15:0] CFG_MAGIC = 16'hC0F6;

  // Header word layout: tag in the upper half, column count in the lower half.
  localparam int HDR_TAG_HI = 31;
  localparam int HDR_TAG_LO = 16;
  localparam int HDR_CNT_HI = 15;
  localparam int HDR_CNT_LO = 0;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PACK,
    SHIFT,
    CHECK,
    DONE,
    ERR
  } state_t;

  // Number of 32-bit stream words needed to fill one column.
  function automatic int words_per_col(input int height);
    return (height + 31) / 32;
  endfunction

endpackage

// File: rtl/cfg_col_packer.sv
// Word-to-column packer: word k of a column lands in bits [32k+31:32k].
// Column is complete on the same edge that writes its last word; bits above
// CFG_HEIGHT are dropped. With CFG_LOADER_CHECKSUM_EN it also XORs payload words.
module cfg_col_packer
  import cfg_pkg::*;
#(
  parameter int CFG_HEIGHT = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr,
  input  logic [31:0]           word,
  output logic                  last,
`ifdef CFG_LOADER_CHECKSUM_EN
  output logic [31:0]           sum,
`endif
  output logic [CFG_HEIGHT-1:0] col
);

  localparam int W  = words_per_col(CFG_HEIGHT);
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  logic [IW-1:0]         idx;
  logic [CFG_HEIGHT-1:0] col_q;

  assign last = (idx == IW'(W - 1));
  assign col  = col_q;

  // Word index and column storage; each bit is written only by the word that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      col_q <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (wr) begin
      for (int b = 0; b < CFG_HEIGHT; b++) begin
        if (IW'(b / 32) == idx) col_q[b] <= word[b % 32];
      end
      idx <= last ? '0 : idx + IW'(1);
    end
  end

`ifdef CFG_LOADER_CHECKSUM_EN
  // Running XOR of every payload word of the current load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      sum <= '0;
    else if (clr) sum <= '0;
    else if (wr)  sum <= sum ^ word;
  end
`endif

endmodule

// File: rtl/cfg_stream_loader.sv
// Fabric config loader: header + payload words -> one shift pulse per CFG_HEIGHT-bit column.
// Latency: W+1 cycles per column with in_valid held; fab_rst released once DONE is reached.
// Backpressure: in_ready low outside HEADER/PACK/CHECK and during abort. Option: CFG_LOADER_CHECKSUM_EN.
module cfg_stream_loader
  import cfg_pkg::*;
#(
  parameter int          CFG_HEIGHT = 40,
  parameter int          CFG_WIDTH  = 16,
  parameter logic [15:0] MAGIC      = CFG_MAGIC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [31:0]           in_data,
  output logic                  in_ready,
  output logic                  shift,
  output logic [CFG_HEIGHT-1:0] cdata,
  output logic                  fab_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [15:0] MAX_COLS = 16'(CFG_WIDTH);

  state_t      state, state_nxt;
  logic [15:0] n_cols, col_cnt, hdr_cnt;
  logic        acc, hdr_ok, last_word, ld_start, pack_wr, last_col;
`ifdef CFG_LOADER_CHECKSUM_EN
  logic [31:0] sum;
`endif

  assign in_ready = ((state == HEADER) || (state == PACK) || (state == CHECK)) && !abort;
  assign acc      = in_valid && in_ready;
  assign pack_wr  = acc && (state == PACK);
  assign hdr_cnt  = in_data[HDR_CNT_HI:HDR_CNT_LO];
  assign hdr_ok   = (in_data[HDR_TAG_HI:HDR_TAG_LO] == MAGIC) &&
                    (hdr_cnt != 16'd0) && (hdr_cnt <= MAX_COLS);
  assign last_col = ((col_cnt + 16'd1) == n_cols);

  cfg_col_packer #(.CFG_HEIGHT(CFG_HEIGHT)) u_packer (
    .clk  (clk),
    .rst  (rst),
    .clr  (ld_start),
    .wr   (pack_wr),
    .word (in_data),
    .last (last_word),
`ifdef CFG_LOADER_CHECKSUM_EN
    .sum  (sum),
`endif
    .col  (cdata)
  );

  // State register plus column count and the latched column total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      n_cols  <= '0;
      col_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (ld_start)   col_cnt <= '0;
      else if (shift) col_cnt <= col_cnt + 16'd1;
      if ((state == HEADER) && acc && hdr_ok) n_cols <= hdr_cnt;
    end
  end

  // Next state and state-decoded outputs; abort overrides any busy-state transition.
  always_comb begin
    state_nxt = state;
    shift     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    fab_rst   = 1'b1;
    ld_start  = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (state == DONE) begin
          done    = 1'b1;
          fab_rst = 1'b0;
        end
        if (state == ERR) err = 1'b1;
        if (start && !abort) begin
          state_nxt = HEADER;
          ld_start  = 1'b1;
        end
      end
      HEADER: begin
        busy = 1'b1;
        if (acc) state_nxt = hdr_ok ? PACK : ERR;
      end
      PACK: begin
        busy = 1'b1;
        if (acc && last_word) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy  = 1'b1;
        shift = 1'b1;
`ifdef CFG_LOADER_CHECKSUM_EN
        state_nxt = last_col ? CHECK : PACK;
`else
        state_nxt = last_col ? DONE : PACK;
`endif
      end
`ifdef CFG_LOADER_CHECKSUM_EN
      CHECK: begin
        busy = 1'b1;
        if (acc) state_nxt = (in_data == sum) ? DONE : ERR;
      end
`endif
      default: state_nxt = IDLE;
    endcase
    if (busy && abort) state_nxt = IDLE;
  end

endmodule
